// File: rtl/oscill_nios_key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : oscill_nios_key_pkg                                       |
// | Purpose  : Shared constants and helpers for the key debouncer.       |
// | Contents : raw key polarity, default debounce length, counter width  |
// |            derivation.                                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package oscill_nios_key_pkg;

  // Board push-buttons pull the pin low when pressed.
  localparam bit KEY_RAW_ACTIVE_LOW = 1'b1;

  // 10 ms at 50 MHz.
  localparam int KEY_DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Width of a counter that has to reach cycles-1; never below one bit.
  function automatic int key_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int KEY_CNT_W_DEFAULT = key_cnt_width(KEY_DEBOUNCE_CYCLES_DEFAULT);

endpackage : oscill_nios_key_pkg
`default_nettype wire

// File: rtl/oscill_nios_key_debounce_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : oscill_nios_key_debounce_cell                             |
// | Purpose  : One key: 2-flop synchronizer, stability counter, accepted |
// |            level and registered press/release strobes.               |
// | Ports    : clk, rst          - clock, synchronous active-high reset  |
// |            i_key_n_raw       - raw asynchronous key pin              |
// |            o_key_out         - debounced level, 1 = pressed          |
// |            o_key_press       - 1-cycle strobe on accepted press      |
// |            o_key_release     - 1-cycle strobe on accepted release    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module oscill_nios_key_debounce_cell
  import oscill_nios_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n_raw,
  output logic o_key_out,
  output logic o_key_press,
  output logic o_key_release
);

  localparam int                 c_cnt_w    = key_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_term_cnt = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_s1;
  logic               r_s2;
  logic               r_st;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_press;
  logic               r_release;

  logic               w_p;
  logic               w_accept;

  // Normalise to 1 = pressed regardless of pin polarity.
  assign w_p      = KEY_RAW_ACTIVE_LOW ? ~r_s2 : r_s2;
  // A differing level has been seen for DEBOUNCE_CYCLES consecutive cycles.
  assign w_accept = (w_p != r_st) && (r_cnt == c_term_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer parks at the released pin level.
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_st      <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_key_n_raw;
      r_s2      <= r_s1;
      // Strobes land in the same cycle the new r_st becomes visible.
      r_press   <= ~r_st & w_accept &  w_p;
      r_release <=  r_st & w_accept & ~w_p;
      if (w_p == r_st) begin
        // Any bounce back to the stable level restarts the count.
        r_cnt <= '0;
      end else if (w_accept) begin
        r_st  <= w_p;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_key_out     = r_st;
  assign o_key_press   = r_press;
  assign o_key_release = r_release;

endmodule : oscill_nios_key_debounce_cell
`default_nettype wire

// File: rtl/oscill_nios_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : oscill_nios_key_debounce                                  |
// | Purpose  : Synchronizes and debounces the active-low board keys and  |
// |            feeds clean active-high levels to the key PIO in_port,    |
// |            plus per-key press/release strobes for local logic.       |
// | Ports    : clk         - system clock                                |
// |            reset       - synchronous active-high reset               |
// |            key_n_raw   - raw board keys, 0 = pressed                 |
// |            key_out     - debounced levels, 1 = pressed               |
// |            key_press   - 1-cycle strobe per key on press             |
// |            key_release - 1-cycle strobe per key on release           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module oscill_nios_key_debounce
  import oscill_nios_key_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_n_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  // Keys are fully independent; one identical cell per key.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
    oscill_nios_key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk           (clk),
      .rst           (reset),
      .i_key_n_raw   (key_n_raw[gi]),
      .o_key_out     (key_out[gi]),
      .o_key_press   (key_press[gi]),
      .o_key_release (key_release[gi])
    );
  end

endmodule : oscill_nios_key_debounce
`default_nettype wire

// File: tb/tb_oscill_nios_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_oscill_nios_key_debounce                               |
// | Purpose  : Directed bench for the key debouncer, DEBOUNCE_CYCLES=4,  |
// |            WIDTH=3. Stimulus pushes hand-computed output events      |
// |            (cycle, level, strobes); a monitor pops and compares them |
// |            whenever the DUT shows a strobe or a level change.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_oscill_nios_key_debounce;

  localparam int c_w   = 3;
  localparam int c_deb = 4;
  // Input driven after edge n shows on key_out after edge n + 2 + c_deb.
  localparam int c_lat = 2 + c_deb;

  typedef struct {
    int             cyc;
    logic [c_w-1:0] out;
    logic [c_w-1:0] press;
    logic [c_w-1:0] rel;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [c_w-1:0] key_n_raw;
  logic [c_w-1:0] key_out;
  logic [c_w-1:0] key_press;
  logic [c_w-1:0] key_release;

  exp_t           r_q[$];
  int             cyc;
  int             n_assert;
  int             n_fail;
  logic [c_w-1:0] prev_out;

  oscill_nios_key_debounce #(
    .WIDTH           (c_w),
    .DEBOUNCE_CYCLES (c_deb)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n_raw   (key_n_raw),
    .key_out     (key_out),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", r_q.size());
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [c_w-1:0] o,
                           input logic [c_w-1:0] p, input logic [c_w-1:0] r);
    exp_t e;
    e.cyc = c; e.out = o; e.press = p; e.rel = r;
    r_q.push_back(e);
  endtask

  // Monitor: every strobe or level change must match the next queued event.
  initial prev_out = '0;
  always @(negedge clk) begin
    exp_t e;
    n_assert++;
    if ((key_press & key_release) !== '0) begin
      n_fail++;
      $display("FAIL strobe_excl cyc=%0d press=%b release=%b required no overlap",
               cyc, key_press, key_release);
    end
    if (key_press !== '0 || key_release !== '0 || key_out !== prev_out) begin
      n_assert++;
      if (r_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d out=%b press=%b release=%b required no event",
                 cyc, key_out, key_press, key_release);
      end else begin
        e = r_q.pop_front();
        if (cyc != e.cyc || key_out !== e.out || key_press !== e.press ||
            key_release !== e.rel) begin
          n_fail++;
          $display("FAIL event cyc=%0d out=%b press=%b release=%b required cyc=%0d out=%b press=%b release=%b",
                   cyc, key_out, key_press, key_release, e.cyc, e.out, e.press, e.rel);
        end
      end
    end
    prev_out = key_out;
  end

  initial begin
    logic [7:0] bounce;
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_n_raw = 3'b000;   // all keys held through reset

    // Reset: outputs stay 0 for all three reset cycles.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_assert++;
      if (key_out !== '0 || key_press !== '0 || key_release !== '0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d out=%b press=%b release=%b required 000",
                 cyc, key_out, key_press, key_release);
      end
    end
    reset = 1'b0;
    expect_ev(cyc + c_lat, 3'b111, 3'b111, 3'b000);
    tick(10);

    // Release everything to start from idle.
    key_n_raw = 3'b111;
    expect_ev(cyc + c_lat, 3'b000, 3'b000, 3'b111);
    tick(10);

    // Clean press/release of key0, held 20 cycles.
    key_n_raw = 3'b110;
    expect_ev(cyc + c_lat, 3'b001, 3'b001, 3'b000);
    tick(20);
    key_n_raw = 3'b111;
    expect_ev(cyc + c_lat, 3'b000, 3'b000, 3'b001);
    tick(10);

    // Bounce on key1: 0,0,0,1,0,0,0,1 then held low.
    bounce = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      key_n_raw = {1'b1, bounce[i], 1'b1};
      tick(1);
    end
    key_n_raw = 3'b101;
    expect_ev(cyc + c_lat, 3'b010, 3'b010, 3'b000);
    tick(12);
    key_n_raw = 3'b111;
    expect_ev(cyc + c_lat, 3'b000, 3'b000, 3'b010);
    tick(10);

    // Short glitch on key2: three cycles low is one short of acceptance.
    key_n_raw = 3'b011;
    tick(3);
    key_n_raw = 3'b111;
    tick(12);

    // Keys 0 and 2 pressed together.
    key_n_raw = 3'b010;
    expect_ev(cyc + c_lat, 3'b101, 3'b101, 3'b000);
    tick(10);

    // Release both, then reset when the counters sit at 2.
    key_n_raw = 3'b111;
    tick(4);
    reset = 1'b1;
    expect_ev(cyc + 1, 3'b000, 3'b000, 3'b000);
    tick(2);
    reset = 1'b0;
    tick(12);

    n_assert++;
    if (r_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events remaining=%0d required 0 (next cyc=%0d)",
               r_q.size(), r_q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_oscill_nios_key_debounce
`default_nettype wire
